// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time, drives a req/ack data bus,
// and returns extended load data or a store completion with error reporting.
module lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Counter only has to reach TIMEOUT-1; the last no-ack cycle ends the request.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          illegal, misaligned;
  logic [3:0]    be_in;
  logic [31:0]   wdata_in;
  logic [31:0]   shifted;
  logic [31:0]   load_data;

  always_comb begin
    illegal = is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                       : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
    misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    case (funct3[1:0])
      2'b00:   be_in = 4'b0001 << addr[1:0];
      2'b01:   be_in = addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   be_in = 4'b1111;
      default: be_in = 4'b0000;
    endcase
    wdata_in = 32'd0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00:   wdata_in = {4{wdata[7:0]}};
        2'b01:   wdata_in = {2{wdata[15:0]}};
        default: wdata_in = wdata;
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      3'b010:  load_data = mem_rdata;
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = is_store;
          addr_d  = {addr[31:2], 2'b00};
          be_d    = be_in;
          wdata_d = wdata_in;
          f3_d    = funct3;
          off_d   = addr[1:0];
          cnt_d   = '0;
          if (illegal || misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : load_data;
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == REQ);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu: per-cycle expectations are laid out from a
// transaction-level model of each op and compared on every falling edge.
module tb_lsu;
  localparam int TO = 4;
  localparam int N  = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit          e_ready[N], e_req[N], e_rsp[N], e_err[N], e_we[N];
  logic [31:0] e_rdata[N], e_addr[N], e_wdata[N];
  logic [3:0]  e_be[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level reference: error flag, load result, bus enables and data.
  function automatic void model(input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] word, output logic bad,
                                output logic [31:0] rd, output logic [3:0] be,
                                output logic [31:0] bwd);
    int nb, off;
    logic [63:0] u;
    off = int'(a % 32'd4);
    if (st) bad = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    bad = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (!bad && (off % nb) != 0) bad = 1'b1;
    be = 4'(((1 << nb) - 1) << off);
    if (!st)          bwd = 32'd0;
    else if (nb == 1) bwd = 32'(wd[7:0]) * 32'h0101_0101;
    else if (nb == 2) bwd = 32'(wd[15:0]) * 32'h0001_0001;
    else              bwd = wd;
    rd = 32'd0;
    if (!bad && !st) begin
      u = ({32'd0, word} >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1);
      if (!f3[2] && nb < 4 && u >= (64'd1 << (8 * nb - 1))) u = u - (64'd1 << (8 * nb));
      rd = u[31:0];
    end
  endfunction

  task automatic set_held(input int r, input bit err, input logic [31:0] rd);
    for (int k = r; k < N; k++) begin
      e_err[k]   = err;
      e_rdata[k] = rd;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    is_store  = 1'($urandom);
    funct3    = 3'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    repeat (n) step();
  endtask

  // Issue one op while the DUT is idle; d = REQ cycle of the ack (>= TO: none).
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int d,
                       input bit late, input bit hold);
    logic bad;
    logic [31:0] rd, bwd;
    logic [3:0] be;
    int c, n, r;
    bit tmo;
    model(st, f3, a, wd, word, bad, rd, be, bwd);
    c   = cyc;
    tmo = !bad && d >= TO;
    n   = bad ? 0 : (tmo ? TO : d + 1);
    r   = c + n + 1;
    for (int i = 1; i <= n; i++) begin
      e_req[c+i]   = 1'b1;
      e_we[c+i]    = st;
      e_addr[c+i]  = {a[31:2], 2'b00};
      e_be[c+i]    = be;
      e_wdata[c+i] = bwd;
    end
    for (int k = c + 1; k <= r; k++) e_ready[k] = 1'b0;
    e_rsp[r] = 1'b1;
    set_held(r, bad || tmo, (bad || tmo) ? 32'd0 : rd);
    req_valid = 1'b1;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    for (int k = c + 1; k <= r + 1; k++) begin
      step();
      if (!hold) req_valid = 1'b0;
      mem_ack   = (!bad && !tmo && k == c + 1 + d) || (tmo && late && k == r);
      mem_rdata = mem_ack ? word : $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      chk("req_ready", 32'(req_ready), 32'(e_ready[cyc]));
      chk("mem_req", 32'(mem_req), 32'(e_req[cyc]));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[cyc]));
      chk("rsp_err", 32'(rsp_err), 32'(e_err[cyc]));
      chk("rsp_rdata", rsp_rdata, e_rdata[cyc]);
      if (e_req[cyc]) begin
        chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
        chk("mem_addr", mem_addr, e_addr[cyc]);
        chk("mem_be", 32'(mem_be), 32'(e_be[cyc]));
        chk("mem_wdata", mem_wdata, e_wdata[cyc]);
      end
    end
  end

  initial begin
    logic bad;
    logic [31:0] rd, bwd;
    logic [3:0] be;
    int c, nops;
    bit hold;

    for (int k = 0; k < N; k++) begin
      e_ready[k] = 1'b1; e_req[k] = 1'b0; e_rsp[k] = 1'b0; e_err[k] = 1'b0;
      e_we[k] = 1'b0; e_rdata[k] = 32'd0; e_addr[k] = 32'd0; e_be[k] = 4'd0;
      e_wdata[k] = 32'd0;
    end
    rst = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

    // Hand-computed values that pin the reference model.
    model(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80FF_1234, bad, rd, be, bwd);
    chk("model_lb_rdata", rd, 32'hFFFF_FF80);
    chk("model_lb_bad", 32'(bad), 32'd0);
    model(1'b0, 3'b101, 32'h1002, 32'd0, 32'h80FF_1234, bad, rd, be, bwd);
    chk("model_lhu_rdata", rd, 32'h0000_80FF);
    model(1'b0, 3'b001, 32'h1002, 32'd0, 32'h80FF_1234, bad, rd, be, bwd);
    chk("model_lh_rdata", rd, 32'hFFFF_80FF);
    model(1'b1, 3'b000, 32'h2001, 32'h1234_56AB, 32'd0, bad, rd, be, bwd);
    chk("model_sb_be", 32'(be), 32'b0010);
    chk("model_sb_wdata", bwd, 32'hABAB_ABAB);
    model(1'b1, 3'b001, 32'h2002, 32'h1234_56AB, 32'd0, bad, rd, be, bwd);
    chk("model_sh_be", 32'(be), 32'b1100);
    chk("model_sh_wdata", bwd, 32'h56AB_56AB);
    model(1'b1, 3'b010, 32'h3002, 32'd0, 32'd0, bad, rd, be, bwd);
    chk("model_sw_misaligned", 32'(bad), 32'd1);
    model(1'b0, 3'b011, 32'h3000, 32'd0, 32'd0, bad, rd, be, bwd);
    chk("model_ld_illegal", 32'(bad), 32'd1);

    step();
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_be", 32'(mem_be), 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    step();
    rst = 1'b0;
    step();

    do_op(1'b0, 3'b000, 32'h1003, 32'd0, 32'h80FF_1234, 0, 1'b0, 1'b0);
    do_op(1'b0, 3'b101, 32'h1002, 32'd0, 32'h80FF_1234, 0, 1'b0, 1'b0);
    do_op(1'b1, 3'b000, 32'h2001, 32'h1234_56AB, 32'd0, 1, 1'b0, 1'b0);
    do_op(1'b1, 3'b001, 32'h2002, 32'h1234_56AB, 32'd0, 0, 1'b0, 1'b0);
    do_op(1'b1, 3'b010, 32'h3002, 32'h1, 32'd0, 0, 1'b0, 1'b0);
    do_op(1'b0, 3'b011, 32'h3000, 32'd0, 32'd0, 0, 1'b0, 1'b0);
    idle(1);
    do_op(1'b0, 3'b010, 32'h5000, 32'd0, 32'h1111_2222, 9, 1'b1, 1'b0);
    do_op(1'b0, 3'b010, 32'h6000, 32'd0, 32'hCAFE_F00D, 3, 1'b0, 1'b1);
    do_op(1'b1, 3'b010, 32'h6004, 32'hDEAD_BEEF, 32'd0, 3, 1'b0, 1'b0);

    // Reset in the second REQ cycle; the later ack must be ignored.
    c = cyc;
    model(1'b0, 3'b010, 32'h4000, 32'd0, 32'd0, bad, rd, be, bwd);
    for (int i = 1; i <= 2; i++) begin
      e_req[c+i] = 1'b1; e_we[c+i] = 1'b0; e_addr[c+i] = 32'h4000;
      e_be[c+i] = be; e_wdata[c+i] = bwd; e_ready[c+i] = 1'b0;
    end
    set_held(c + 3, 1'b0, 32'd0);
    req_valid = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h4000;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    step();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 1'b0;
    step();

    nops = 250;
    hold = 1'b0;
    for (int i = 0; i < nops; i++) begin
      hold = (i != nops - 1) && ($urandom_range(0, 3) == 0);
      do_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            int'($urandom_range(0, 6)), 1'($urandom), hold);
      if (!hold) idle(int'($urandom_range(0, 2)));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
